// File: rtl/sint_shift_pipe_pkg.sv
// Shared types for the pipelined shifter: operation encoding and stage split helper.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  // Barrel levels per register stage; earlier stages take the ceiling share.
  function automatic int levels_per_stage(input int width, input int stages);
    int lv;
    lv = $clog2(width);
    return (lv + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/sint_shift_pipe_level.sv
// One combinational barrel level: shifts by SHIFT when the amount bit is set.
// Rotate muxing only exists when SINT_SHIFT_PIPE_ROTATE_EN is defined.
module sint_shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] word_i,
  input  shift_mode_e      mode_i,
  input  logic             amt_bit_i,
  output logic [WIDTH-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    if (amt_bit_i) begin
      unique case (mode_i)
        MODE_LSL: word_o = word_i << SHIFT;
        MODE_LSR: word_o = word_i >> SHIFT;
        MODE_ASR: word_o = WIDTH'($signed(word_i) >>> SHIFT);
`ifdef SINT_SHIFT_PIPE_ROTATE_EN
        MODE_ROR: word_o = (word_i >> SHIFT) | (word_i << (WIDTH - SHIFT));
`else
        MODE_ROR: word_o = WIDTH'($signed(word_i) >>> SHIFT);
`endif
        default:  word_o = word_i;
      endcase
    end
  end

endmodule

// File: rtl/sint_shift_pipe.sv
// Pipelined signed/unsigned barrel shifter with valid/ready on both sides.
// Define SINT_SHIFT_PIPE_ROTATE_EN to make mode 2'b11 a rotate right; otherwise it is ASR.
module sint_shift_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LPS    = levels_per_stage(WIDTH, STAGES);

  typedef struct packed {
    logic              vld;
    logic              oor;
    shift_mode_e       mode;
    logic [LEVELS-1:0] amt;
    logic [WIDTH-1:0]  word;
  } stage_t;

  stage_t           front;
  stage_t           stg_in   [STAGES];
  stage_t           stg_d    [STAGES];
  stage_t           stg_q    [STAGES];
  logic [WIDTH-1:0] stg_word [STAGES];
  logic [WIDTH-1:0] lvl_in   [LEVELS];
  logic [WIDTH-1:0] lvl_out  [LEVELS];
  logic             en;
  shift_mode_e      mode_n;
  logic             oor;
`ifdef SINT_SHIFT_PIPE_ROTATE_EN
  logic [WIDTH-1:0] amt_mod;
`endif

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign out_valid = stg_q[STAGES-1].vld;
  assign out_data  = stg_q[STAGES-1].word;

  // Range detect. Out-of-range non-rotate shifts run with every amount bit set,
  // which sign-fills ASR; LSL/LSR are zeroed at the last stage from the flag.
  always_comb begin
    mode_n = shift_mode_e'(in_mode);
`ifndef SINT_SHIFT_PIPE_ROTATE_EN
    if (mode_n == MODE_ROR) mode_n = MODE_ASR;
`endif
    oor        = (in_amt >= WIDTH'(WIDTH));
    front      = '0;
    front.vld  = in_valid;
    front.oor  = oor;
    front.mode = mode_n;
    front.word = in_data;
    front.amt  = oor ? '1 : in_amt[LEVELS-1:0];
`ifdef SINT_SHIFT_PIPE_ROTATE_EN
    amt_mod = in_amt % WIDTH'(WIDTH);
    if (mode_n == MODE_ROR) front.amt = amt_mod[LEVELS-1:0];
`endif
  end

  always_comb begin
    stg_in[0] = front;
    for (int s = 1; s < STAGES; s++) stg_in[s] = stg_q[s-1];
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int SI = l / LPS;
    if ((l % LPS) == 0) begin : g_first
      assign lvl_in[l] = stg_in[SI].word;
    end else begin : g_chain
      assign lvl_in[l] = lvl_out[l-1];
    end
    sint_shift_level #(.WIDTH(WIDTH), .SHIFT(1 << l)) u_lvl (
      .word_i    (lvl_in[l]),
      .mode_i    (stg_in[SI].mode),
      .amt_bit_i (stg_in[SI].amt[l]),
      .word_o    (lvl_out[l])
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int FIRST_L = s * LPS;
    localparam int LAST_L  = (((s + 1) * LPS) < LEVELS ? ((s + 1) * LPS) : LEVELS) - 1;
    if (FIRST_L <= LAST_L) begin : g_work
      assign stg_word[s] = lvl_out[LAST_L];
    end else begin : g_pass
      assign stg_word[s] = stg_in[s].word;
    end
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      stg_d[s]      = stg_in[s];
      stg_d[s].word = stg_word[s];
    end
    if (stg_in[STAGES-1].oor &&
        (stg_in[STAGES-1].mode == MODE_LSL || stg_in[STAGES-1].mode == MODE_LSR))
      stg_d[STAGES-1].word = '0;
  end

  // Global advance: every stage loads together, bubbles included.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) stg_q[s] <= stg_d[s];
    end
  end

endmodule

// File: tb/tb_sint_shift_pipe.sv
// Scoreboard bench for sint_shift_pipe: three configurations share clock and reset.
module tb_sint_shift_pipe;

  localparam int NDUT = 3;
  localparam int W0 = 3,  S0 = 2;
  localparam int W1 = 16, S1 = 4;
  localparam int W2 = 8,  S2 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0]       in_valid, in_ready, out_valid, out_ready, lat_chk;
  logic [NDUT-1:0][31:0] in_data, in_amt, out_data;
  logic [NDUT-1:0][1:0]  in_mode;
  logic [W0-1:0] od0;
  logic [W1-1:0] od1;
  logic [W2-1:0] od2;

  always_comb begin
    out_data[0] = 32'(od0);
    out_data[1] = 32'(od1);
    out_data[2] = 32'(od2);
  end

  sint_shift_pipe #(.WIDTH(W0), .STAGES(S0)) u_d0 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][W0-1:0]), .in_amt(in_amt[0][W0-1:0]), .in_mode(in_mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0));
  sint_shift_pipe #(.WIDTH(W1), .STAGES(S1)) u_d1 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][W1-1:0]), .in_amt(in_amt[1][W1-1:0]), .in_mode(in_mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1));
  sint_shift_pipe #(.WIDTH(W2), .STAGES(S2)) u_d2 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][W2-1:0]), .in_amt(in_amt[2][W2-1:0]), .in_mode(in_mode[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2));

  function automatic int wdt(input int k);
    case (k)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  function automatic int stg(input int k);
    case (k)
      0:       return S0;
      1:       return S1;
      default: return S2;
    endcase
  endfunction

  // Reference: shift semantics from the arithmetic definition of each mode.
  function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d,
                                            input logic [31:0] a, input logic [1:0] m);
    longint unsigned mask, x, amt, r;
    bit s;
    logic [1:0] mm;
    mask = (64'd1 << w) - 1;
    x    = longint'(d) & mask;
    amt  = longint'(a) & mask;
    s    = x[w-1];
    mm   = m;
`ifdef SINT_SHIFT_PIPE_ROTATE_EN
    if (mm == 2'b11) begin
      r = amt % longint'(w);
      return 32'(((x >> r) | (x << (w - r))) & mask);
    end
`else
    if (mm == 2'b11) mm = 2'b10;
`endif
    case (mm)
      2'b00:   return (amt >= longint'(w)) ? 32'd0 : 32'((x << amt) & mask);
      2'b01:   return (amt >= longint'(w)) ? 32'd0 : 32'(x >> amt);
      default: begin
        if (amt >= longint'(w)) return s ? 32'(mask) : 32'd0;
        return 32'((x >> amt) | (s ? (mask & ~(mask >> amt)) : 64'd0));
      end
    endcase
  endfunction

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t exp_q [NDUT][$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Monitor: pushes on acceptance, pops and compares on output transfer.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        exp_q[k].delete();
      end else begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_chk++;
            $display("FAIL spurious_out dut%0d: got %0h, expected no output", k, out_data[k]);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("data dut%0d", k), out_data[k], e.val);
            if (lat_chk[k]) chk($sformatf("latency dut%0d", k), 32'(cyc - e.cyc), 32'(stg(k)));
          end
        end
        if (in_valid[k] && in_ready[k]) begin
          e.val = ref_shift(wdt(k), in_data[k], in_amt[k], in_mode[k]);
          e.cyc = cyc;
          exp_q[k].push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [31:0] d, input logic [31:0] a,
                          input logic [1:0] m);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_amt[k]   = a;
    in_mode[k]  = m;
  endtask

  task automatic send(input int k, input logic [31:0] d, input logic [31:0] a,
                      input logic [1:0] m);
    set_word(k, d, a, m);
    step();
  endtask

  task automatic set_rnd(input int k);
    logic [31:0] mask, a;
    int w;
    w    = wdt(k);
    mask = 32'((64'd1 << w) - 1);
    if ($urandom_range(0, 3) == 0) a = $urandom & mask;
    else a = 32'($urandom_range(0, w + 1)) & mask;
    set_word(k, $urandom & mask, a, 2'($urandom_range(0, 3)));
  endtask

  task automatic drain();
    int busy;
    for (int k = 0; k < NDUT; k++) in_valid[k] = 1'b0;
    busy = 1;
    for (int i = 0; i < 200 && busy != 0; i++) begin
      step();
      busy = 0;
      for (int k = 0; k < NDUT; k++) busy += exp_q[k].size();
    end
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("drain_pending dut%0d", k), 32'(exp_q[k].size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = '1;
    lat_chk   = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_out_valid dut%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst_out_data dut%0d", k), out_data[k], 32'd0);
      chk($sformatf("rst_in_ready dut%0d", k), 32'(in_ready[k]), 32'd1);
    end
    step();

    // WIDTH=3 directed vectors, then random traffic.
    lat_chk[0] = 1'b1;
    send(0, 32'b100, 32'd1, 2'b10);
    send(0, 32'b100, 32'd5, 2'b10);
    send(0, 32'b101, 32'd3, 2'b01);
    send(0, 32'b011, 32'd1, 2'b00);
    repeat (20) begin set_rnd(0); step(); end
    drain();

    // WIDTH=16, STAGES=4: 100 back-to-back random words.
    lat_chk[1] = 1'b1;
    repeat (100) begin set_rnd(1); step(); end
    drain();
    lat_chk[1] = 1'b0;

    // Fill, then stall for 5 cycles while still offering words.
    repeat (6) begin set_rnd(1); step(); end
    out_ready[1] = 1'b0;
    set_rnd(1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready[1]), 32'd0);
      chk("stall_out_valid", 32'(out_valid[1]), 32'd1);
      if (exp_q[1].size() > 0) chk("stall_out_data", out_data[1], exp_q[1][0].val);
      step();
      set_rnd(1);
    end
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b0;
    drain();

    // Random valid and backpressure.
    repeat (80) begin
      set_rnd(1);
      in_valid[1]  = 1'($urandom_range(0, 1));
      out_ready[1] = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready[1] = 1'b1;
    drain();

    // Reset with two words in flight plus one word offered during reset.
    set_rnd(1); step();
    set_rnd(1); step();
    set_rnd(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("post_reset_out_valid dut%0d", k), 32'(out_valid[k]), 32'd0);
    seen = 0;
    repeat (8) begin
      step();
      @(negedge clk);
      if (out_valid[1]) seen++;
    end
    chk("post_reset_outputs", 32'(seen), 32'd0);
    step();

    // WIDTH=8 mode 2'b11 vectors, then random traffic.
    lat_chk[2] = 1'b1;
    send(2, 32'h81, 32'd1, 2'b11);
    send(2, 32'h03, 32'd1, 2'b11);
    repeat (20) begin set_rnd(2); step(); end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sint_shift_pipe.md
# sint_shift_pipe

Parametrised, pipelined barrel shifter for signed and unsigned words. It extends the single-mode combinational arithmetic-shift-right primitive with run-time mode selection, a configurable number of register stages and a valid/ready handshake on both sides. It sits in the datapath wherever shifts must meet timing at wide widths, and is driven by the same integer types as the binary-op primitives.

## Interface
- WIDTH, 16: operand and result width in bits, at least 2.
- STAGES, 2: number of register stages, from 1 to clog2(WIDTH). The clog2(WIDTH) barrel levels are split across the stages, with earlier stages taking ceil(levels/STAGES) each.
- CLK  input  1  clock; every register is rising-edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  WIDTH  shift amount, unsigned.
- in_mode  input  2  operation, encoded in shifter_pkg.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result.

## Operation
- Modes: 2'b00 LSL (logical shift left), 2'b01 LSR (logical shift right), 2'b10 ASR (arithmetic shift right, sign-filled), 2'b11 ROR (see Configuration).
- Out-of-range amounts (in_amt >= WIDTH) are detected in stage 0 and carried forward as a flag:
  - LSL and LSR produce 0.
  - ASR produces all copies of in_data[WIDTH-1].
  - ROR uses in_amt mod WIDTH and ignores the flag.
- Result is identical to a single-cycle shift on the same operands. Only latency differs.
- Each stage register holds a valid bit, the partial word, the remaining amount bits, the mode and the range flag.
- Pipeline uses a global advance: en = out_ready | ~out_valid. All stages load when en is high and hold when it is low.
- in_ready = en. A word is accepted when in_valid & in_ready.
- Bubbles are not collapsed. An invalid slot still takes one position.
- Valid bits shift in lock-step with the data.
- Data registers may load garbage when their valid bit is 0. The bench only checks out_data when out_valid is 1.

## Timing
- Latency is STAGES cycles from acceptance to out_valid, with no backpressure.
- Throughput is one word per cycle while out_ready is held high.
- Reset values: out_valid=0, out_data=0, in_ready=1 in the cycle after RESET deasserts. All valid bits clear, and all data registers clear to 0.
- RESET during operation discards every in-flight word on that edge. No partial results are emitted.
- RESET together with in_valid: the word is dropped.
- Backpressure (out_valid=1, out_ready=0):
  - out_data and out_valid hold stable.
  - in_ready=0 in the same cycle, which is a combinational path from out_ready.
- out_valid=1 and out_ready=1 in the same cycle as a new acceptance: both transfers complete and the pipeline shifts by one.
- When STAGES=1, the stage-0 register is the output register.

## Configuration
- SINT_SHIFT_PIPE_ROTATE_EN defined:
  - mode 2'b11 is ROR (rotate right by in_amt mod WIDTH).
  - The rotate muxing is present in every level.
- SINT_SHIFT_PIPE_ROTATE_EN undefined:
  - mode 2'b11 behaves exactly as ASR.
  - No rotate logic is generated.

## Structure
- shifter_pkg holds:
  - the typedef shift_mode_e with values MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR.
  - a function that computes levels per stage from WIDTH and STAGES.
- Sub-module sint_shift_level performs one barrel level.
  - Parameters: WIDTH and SHIFT (power of two).
  - Inputs: word, mode, one amount bit.
  - It is combinational, and the top instantiates clog2(WIDTH) of them.
- Top sint_shift_pipe holds the range detect, the stage registers and the handshake.

## Test plan
- WIDTH=3, STAGES=2, ASR 3'b100 by 1, out_ready=1 -> out_data=3'b110 with out_valid exactly 2 cycles after acceptance.
- WIDTH=3, ASR 3'b100 by 5 and LSR 3'b101 by 3 -> 3'b111, then 3'b000. LSL 3'b011 by 1 -> 3'b110.
- WIDTH=16, STAGES=4, 100 random back-to-back words with out_ready=1 -> one result per cycle, matching a reference model in order.
- Fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable, no loss or duplication after release.
- Assert RESET with 2 words in flight -> out_valid=0 next cycle, and neither word ever appears.
- mode 2'b11, WIDTH=8, 8'h81 by 1 -> 8'hC0 with the macro defined. Without it, the same arithmetic-shift result 8'hC0 is produced; a second vector, 8'h03 by 1, distinguishes them: 8'h81 (ROR) versus 8'h01 (ASR).
